// File: rtl/layer0_writeback.sv
// layer0_writeback: consumer end of the layer-0 convolution stream.
//   Captures one row-pair burst (2*IMG_W result pairs), ReLUs it, drains all
//   entries to layer-0 memory, then writes the 2x2 max-pool to layer-1 memory.
// Ports: clk/reset; i_start -> o_busy/o_done; i_valid + i_data_0/1 in;
//   o_go_down paces the producer; o_cwr/o_csel/o_caddr/o_cdata shared write
//   port (registered, one cycle per write); o_err sticky protocol error.
module layer0_writeback #(
  parameter int DW      = 20,
  parameter int IMG_W   = 64,
  parameter int N_PAIRS = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_start,
  output logic          o_busy,
  input  logic          i_valid,
  input  logic [DW-1:0] i_data_0,
  input  logic [DW-1:0] i_data_1,
  output logic          o_go_down,
  output logic          o_cwr,
  output logic [2:0]    o_csel,
  output logic [11:0]   o_caddr,
  output logic [DW-1:0] o_cdata,
  output logic          o_done,
  output logic          o_err
);

  localparam int CW = $clog2(IMG_W);    // column bits
  localparam int NE = 2 * IMG_W;        // entries per burst
  localparam int IW = CW + 2;           // counts 0..NE inclusive
  localparam int PW = $clog2(N_PAIRS);  // pair bits
  localparam logic [IW-1:0] NE_C   = IW'(NE);
  localparam logic [PW-1:0] LAST_P = PW'(N_PAIRS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FILL, S_DRAIN, S_POOL, S_HANDOFF, S_FINISH
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pair_q, pair_d;
  logic [IW-1:0]   cap_cnt_q, cap_cnt_d;
  logic [IW-1:0]   wr_idx_q, wr_idx_d;
  logic            wr_k_q, wr_k_d;
  logic [CW-1:0]   pool_cnt_q, pool_cnt_d;   // {p, kernel}
  logic            err_q, err_d;
  logic            cwr_q, cwr_d;
  logic [2:0]      csel_q, csel_d;
  logic [11:0]     caddr_q, caddr_d;
  logic [DW-1:0]   cdata_q, cdata_d;

  logic [DW-1:0]   mem0_q [NE];
  logic [DW-1:0]   mem1_q [NE];
  logic            cap_we;
  logic [DW-1:0]   cap_dat0, cap_dat1;

  // ReLU is applied on capture, so everything downstream is unsigned.
  assign cap_dat0 = i_data_0[DW-1] ? '0 : i_data_0;
  assign cap_dat1 = i_data_1[DW-1] ? '0 : i_data_1;

  function automatic logic [DW-1:0] umax(input logic [DW-1:0] a, input logic [DW-1:0] b);
    return (a > b) ? a : b;
  endfunction

  // Pool window for p: entries 2p, 2p+1 (upper row) and 64+2p, 65+2p (lower row).
  logic [CW-2:0] pool_p;
  logic [DW-1:0] pool_max;
  always_comb begin
    pool_p = pool_cnt_q[CW-1:1];
    if (pool_cnt_q[0]) begin
      pool_max = umax(umax(mem1_q[{1'b0, pool_p, 1'b0}], mem1_q[{1'b0, pool_p, 1'b1}]),
                      umax(mem1_q[{1'b1, pool_p, 1'b0}], mem1_q[{1'b1, pool_p, 1'b1}]));
    end else begin
      pool_max = umax(umax(mem0_q[{1'b0, pool_p, 1'b0}], mem0_q[{1'b0, pool_p, 1'b1}]),
                      umax(mem0_q[{1'b1, pool_p, 1'b0}], mem0_q[{1'b1, pool_p, 1'b1}]));
    end
  end

  always_comb begin
    state_d    = state_q;
    pair_d     = pair_q;
    cap_cnt_d  = cap_cnt_q;
    wr_idx_d   = wr_idx_q;
    wr_k_d     = wr_k_q;
    pool_cnt_d = pool_cnt_q;
    err_d      = err_q;
    cwr_d      = 1'b0;
    csel_d     = 3'd0;
    caddr_d    = '0;
    cdata_d    = '0;
    cap_we     = 1'b0;

    // Samples outside FILL or beyond a full burst are dropped and flagged.
    if (i_valid) begin
      if (state_q == S_FILL && cap_cnt_q < NE_C) begin
        cap_we    = 1'b1;
        cap_cnt_d = cap_cnt_q + 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_FILL;
          pair_d     = '0;
          cap_cnt_d  = '0;
          wr_idx_d   = '0;
          wr_k_d     = 1'b0;
          pool_cnt_d = '0;
        end
      end
      S_FILL, S_DRAIN: begin
        // L0 drain trails capture; compare against the registered count so a
        // freshly captured entry is only read back from the next cycle on.
        if (wr_idx_q < cap_cnt_q) begin
          cwr_d   = 1'b1;
          csel_d  = wr_k_q ? 3'd2 : 3'd1;
          caddr_d = 12'({pair_q, wr_idx_q[CW:0]});
          cdata_d = wr_k_q ? mem1_q[wr_idx_q[CW:0]] : mem0_q[wr_idx_q[CW:0]];
          wr_k_d  = ~wr_k_q;
          if (wr_k_q) wr_idx_d = wr_idx_q + 1'b1;
        end
        if (state_q == S_FILL) begin
          if (cap_cnt_d == NE_C) state_d = S_DRAIN;
        end else if (wr_idx_q == NE_C) begin
          state_d = S_POOL;
        end
      end
      S_POOL: begin
        cwr_d      = 1'b1;
        csel_d     = pool_cnt_q[0] ? 3'd4 : 3'd3;
        caddr_d    = 12'({pair_q, pool_p});
        cdata_d    = pool_max;
        pool_cnt_d = pool_cnt_q + 1'b1;
        if (pool_cnt_q == '1) state_d = (pair_q == LAST_P) ? S_FINISH : S_HANDOFF;
      end
      S_HANDOFF: begin
        state_d    = S_FILL;
        pair_d     = pair_q + 1'b1;
        cap_cnt_d  = '0;
        wr_idx_d   = '0;
        wr_k_d     = 1'b0;
        pool_cnt_d = '0;
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      pair_q     <= '0;
      cap_cnt_q  <= '0;
      wr_idx_q   <= '0;
      wr_k_q     <= 1'b0;
      pool_cnt_q <= '0;
      err_q      <= 1'b0;
      cwr_q      <= 1'b0;
      csel_q     <= 3'd0;
      caddr_q    <= '0;
      cdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pair_q     <= pair_d;
      cap_cnt_q  <= cap_cnt_d;
      wr_idx_q   <= wr_idx_d;
      wr_k_q     <= wr_k_d;
      pool_cnt_q <= pool_cnt_d;
      err_q      <= err_d;
      cwr_q      <= cwr_d;
      csel_q     <= csel_d;
      caddr_q    <= caddr_d;
      cdata_q    <= cdata_d;
    end
  end

  // Buffer contents need no reset; every entry is written before it is read.
  always_ff @(posedge clk) begin
    if (cap_we) begin
      mem0_q[cap_cnt_q[CW:0]] <= cap_dat0;
      mem1_q[cap_cnt_q[CW:0]] <= cap_dat1;
    end
  end

  assign o_busy    = (state_q == S_FILL) || (state_q == S_DRAIN) ||
                     (state_q == S_POOL) || (state_q == S_HANDOFF);
  assign o_go_down = (state_q == S_HANDOFF);
  assign o_done    = (state_q == S_FINISH);
  assign o_err     = err_q;
  assign o_cwr     = cwr_q;
  assign o_csel    = csel_q;
  assign o_caddr   = caddr_q;
  assign o_cdata   = cdata_q;

endmodule

// File: tb/tb_layer0_writeback.sv
module tb_layer0_writeback;
  localparam int DW = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          i_start = 1'b0;
  logic          i_valid = 1'b0;
  logic [DW-1:0] i_data_0 = '0;
  logic [DW-1:0] i_data_1 = '0;
  logic          o_busy, o_go_down, o_cwr, o_done, o_err;
  logic [2:0]    o_csel;
  logic [11:0]   o_caddr;
  logic [DW-1:0] o_cdata;

  always #5 clk = ~clk;

  layer0_writeback #(.DW(DW), .IMG_W(64), .N_PAIRS(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .o_busy(o_busy),
    .i_valid(i_valid), .i_data_0(i_data_0), .i_data_1(i_data_1),
    .o_go_down(o_go_down), .o_cwr(o_cwr), .o_csel(o_csel), .o_caddr(o_caddr),
    .o_cdata(o_cdata), .o_done(o_done), .o_err(o_err)
  );

  typedef struct packed {
    logic [2:0]    sel;
    logic [11:0]   addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           exp_q[$];
  int            tests = 0;
  int            fails = 0;
  int            l0_cnt, l1_cnt, go_cnt, done_cnt;
  logic [11:0]   last_l1_addr;
  logic [DW-1:0] k0_a0, k1_a0;
  logic [DW-1:0] d0_a [128];
  logic [DW-1:0] d1_a [128];

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return v[DW-1] ? '0 : v;
  endfunction

  function automatic logic [DW-1:0] max4(input logic [DW-1:0] a, b, c, d);
    logic [DW-1:0] m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Expected writes of one burst: all L0 writes in entry order, then pooling.
  task automatic push_burst(input int pair);
    wr_t w;
    for (int i = 0; i < 128; i++) begin
      w.sel = 3'd1; w.addr = 12'(pair * 128 + i); w.data = relu(d0_a[i]); exp_q.push_back(w);
      w.sel = 3'd2; w.addr = 12'(pair * 128 + i); w.data = relu(d1_a[i]); exp_q.push_back(w);
    end
    for (int p = 0; p < 32; p++) begin
      w.sel  = 3'd3;
      w.addr = 12'(pair * 32 + p);
      w.data = max4(relu(d0_a[2*p]), relu(d0_a[2*p+1]), relu(d0_a[64+2*p]), relu(d0_a[65+2*p]));
      exp_q.push_back(w);
      w.sel  = 3'd4;
      w.data = max4(relu(d1_a[2*p]), relu(d1_a[2*p+1]), relu(d1_a[64+2*p]), relu(d1_a[65+2*p]));
      exp_q.push_back(w);
    end
  endtask

  task automatic monitor();
    wr_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (o_go_down) go_cnt++;
        if (o_done) done_cnt++;
        if (o_cwr) begin
          if (o_csel == 3'd1 || o_csel == 3'd2) l0_cnt++;
          else l1_cnt++;
          if (o_csel == 3'd3 && o_caddr == 12'h000) k0_a0 = o_cdata;
          if (o_csel == 3'd4 && o_caddr == 12'h000) k1_a0 = o_cdata;
          if (o_csel >= 3'd3) last_l1_addr = o_caddr;
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_write: got sel=%0d addr=%h data=%h, required no write", o_csel, o_caddr, o_cdata);
          end else begin
            e = exp_q.pop_front();
            if ({o_csel, o_caddr, o_cdata} !== e) begin
              fails++;
              $display("FAIL write: got sel=%0d addr=%h data=%h, required sel=%0d addr=%h data=%h",
                       o_csel, o_caddr, o_cdata, e.sel, e.addr, e.data);
            end
          end
        end
      end
    end
  endtask

  task automatic clear_counts();
    exp_q.delete();
    l0_cnt = 0; l1_cnt = 0; go_cnt = 0; done_cnt = 0;
    last_l1_addr = '0; k0_a0 = '1; k1_a0 = '1;
  endtask

  task automatic do_reset();
    reset = 1'b1; i_start = 1'b0; i_valid = 1'b0; i_data_0 = '0; i_data_1 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();
  endtask

  task automatic start();
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  // Streams d0_a/d1_a with random gaps, optional stray valids, then waits
  // (bounded) for the end-of-burst pulse.
  task automatic send_burst(input int gap_max, input bit extra, input bit last, input bit poke);
    int g0, dn0, lb;
    g0 = go_cnt; dn0 = done_cnt; lb = l1_cnt;
    for (int i = 0; i < 128; i++) begin
      i_valid = 1'b0;
      repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
      i_valid = 1'b1; i_data_0 = d0_a[i]; i_data_1 = d1_a[i];
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    if (extra) begin
      i_valid = 1'b1; i_data_0 = 20'h00123; i_data_1 = 20'h00456;
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
    if (poke) begin
      for (int c = 0; c < 2000 && l1_cnt == lb; c++) @(posedge clk);
      #1;
      i_valid = 1'b1; i_data_0 = 20'h0ABCD; i_data_1 = 20'h0DCBA;
      @(posedge clk); #1;
      i_valid = 1'b0;
    end
    for (int c = 0; c < 3000 && go_cnt == g0 && done_cnt == dn0; c++) @(posedge clk);
    #1;
    tests++;
    if (last ? (done_cnt == dn0) : (go_cnt == g0)) begin
      fails++;
      $display("FAIL burst_end: got no %s pulse, required one", last ? "done" : "go_down");
    end
  endtask

  task automatic test_reset();
    do_reset();
    tests += 8;
    if (o_busy !== 1'b0)    begin fails++; $display("FAIL rst_busy: got %b, required 0", o_busy); end
    if (o_cwr !== 1'b0)     begin fails++; $display("FAIL rst_cwr: got %b, required 0", o_cwr); end
    if (o_csel !== 3'd0)    begin fails++; $display("FAIL rst_csel: got %0d, required 0", o_csel); end
    if (o_caddr !== 12'd0)  begin fails++; $display("FAIL rst_caddr: got %h, required 0", o_caddr); end
    if (o_cdata !== '0)     begin fails++; $display("FAIL rst_cdata: got %h, required 0", o_cdata); end
    if (o_go_down !== 1'b0) begin fails++; $display("FAIL rst_go_down: got %b, required 0", o_go_down); end
    if (o_done !== 1'b0)    begin fails++; $display("FAIL rst_done: got %b, required 0", o_done); end
    if (o_err !== 1'b0)     begin fails++; $display("FAIL rst_err: got %b, required 0", o_err); end
  endtask

  task automatic test_single_burst();
    do_reset();
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'(i); d1_a[i] = DW'(i + 1000); end
    push_burst(0);
    start();
    tests++;
    if (o_busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %b, required 1", o_busy); end
    send_burst(0, 1'b0, 1'b0, 1'b0);
    tests += 7;
    if (exp_q.size() != 0) begin fails++; $display("FAIL sb_pending: got %0d left, required 0", exp_q.size()); end
    if (l0_cnt != 256)     begin fails++; $display("FAIL sb_l0_count: got %0d, required 256", l0_cnt); end
    if (l1_cnt != 64)      begin fails++; $display("FAIL sb_l1_count: got %0d, required 64", l1_cnt); end
    if (go_cnt != 1)       begin fails++; $display("FAIL sb_go_down: got %0d, required 1", go_cnt); end
    if (k0_a0 !== 20'd65)  begin fails++; $display("FAIL sb_pool_k0: got %0d, required 65", k0_a0); end
    if (k1_a0 !== 20'd1065) begin fails++; $display("FAIL sb_pool_k1: got %0d, required 1065", k1_a0); end
    if (o_busy !== 1'b1)   begin fails++; $display("FAIL sb_busy: got %b, required 1", o_busy); end
  endtask

  task automatic test_relu();
    do_reset();
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'($urandom); d1_a[i] = DW'($urandom); end
    d0_a[0] = 20'hFFFFF; d0_a[1] = 20'h80000; d0_a[2] = 20'h7FFFF;
    d1_a[0] = 20'h7FFFF; d1_a[1] = 20'hFFFFF; d1_a[2] = 20'h80000;
    push_burst(0);
    start();
    send_burst(2, 1'b0, 1'b0, 1'b0);
    tests += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL relu_pending: got %0d left, required 0", exp_q.size()); end
    if (o_err !== 1'b0)    begin fails++; $display("FAIL relu_err: got %b, required 0", o_err); end
  endtask

  task automatic test_pool();
    do_reset();
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'($urandom_range(0, 4)); d1_a[i] = DW'($urandom); end
    d0_a[0] = 20'd5; d0_a[1] = 20'd9; d0_a[64] = 20'd3; d0_a[65] = 20'd7;
    d1_a[0] = 20'hFFFFF; d1_a[1] = 20'h80000; d1_a[64] = 20'h80001; d1_a[65] = 20'hC0000;
    push_burst(0);
    start();
    send_burst(1, 1'b0, 1'b0, 1'b0);
    tests += 3;
    if (k0_a0 !== 20'd9)   begin fails++; $display("FAIL pool_max: got %0d, required 9", k0_a0); end
    if (k1_a0 !== 20'd0)   begin fails++; $display("FAIL pool_neg: got %0d, required 0", k1_a0); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL pool_pending: got %0d left, required 0", exp_q.size()); end
  endtask

  task automatic test_full_image();
    do_reset();
    start();
    for (int pr = 0; pr < 32; pr++) begin
      for (int i = 0; i < 128; i++) begin d0_a[i] = DW'($urandom); d1_a[i] = DW'($urandom); end
      push_burst(pr);
      send_burst(3, 1'b0, pr == 31, 1'b0);
    end
    @(posedge clk); #1;
    tests += 8;
    if (l0_cnt != 8192)           begin fails++; $display("FAIL full_l0_count: got %0d, required 8192", l0_cnt); end
    if (l1_cnt != 2048)           begin fails++; $display("FAIL full_l1_count: got %0d, required 2048", l1_cnt); end
    if (go_cnt != 31)             begin fails++; $display("FAIL full_go_down: got %0d, required 31", go_cnt); end
    if (done_cnt != 1)            begin fails++; $display("FAIL full_done: got %0d, required 1", done_cnt); end
    if (last_l1_addr !== 12'h3FF) begin fails++; $display("FAIL full_last_addr: got %h, required 3ff", last_l1_addr); end
    if (exp_q.size() != 0)        begin fails++; $display("FAIL full_pending: got %0d left, required 0", exp_q.size()); end
    if (o_busy !== 1'b0)          begin fails++; $display("FAIL full_busy: got %b, required 0", o_busy); end
    if (o_err !== 1'b0)           begin fails++; $display("FAIL full_err: got %b, required 0", o_err); end
  endtask

  task automatic test_err();
    do_reset();
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'($urandom); d1_a[i] = DW'($urandom); end
    push_burst(0);
    start();
    send_burst(1, 1'b1, 1'b0, 1'b1);
    tests += 4;
    if (o_err !== 1'b1)    begin fails++; $display("FAIL err_flag: got %b, required 1", o_err); end
    if (exp_q.size() != 0) begin fails++; $display("FAIL err_pending: got %0d left, required 0", exp_q.size()); end
    if (l0_cnt != 256)     begin fails++; $display("FAIL err_l0_count: got %0d, required 256", l0_cnt); end
    if (l1_cnt != 64)      begin fails++; $display("FAIL err_l1_count: got %0d, required 64", l1_cnt); end
  endtask

  task automatic test_reset_mid();
    int w0;
    do_reset();
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'($urandom); d1_a[i] = DW'($urandom); end
    push_burst(0);
    start();
    for (int i = 0; i < 40; i++) begin
      i_valid = 1'b1; i_data_0 = d0_a[i]; i_data_1 = d1_a[i];
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    #3;
    tests++;
    if (o_cwr !== 1'b1) begin fails++; $display("FAIL mid_pre_cwr: got %b, required 1", o_cwr); end
    reset = 1'b1;
    #1;
    tests += 5;
    if (o_busy !== 1'b0)   begin fails++; $display("FAIL mid_busy: got %b, required 0", o_busy); end
    if (o_cwr !== 1'b0)    begin fails++; $display("FAIL mid_cwr: got %b, required 0", o_cwr); end
    if (o_csel !== 3'd0)   begin fails++; $display("FAIL mid_csel: got %0d, required 0", o_csel); end
    if (o_caddr !== 12'd0) begin fails++; $display("FAIL mid_caddr: got %h, required 0", o_caddr); end
    if (o_cdata !== '0)    begin fails++; $display("FAIL mid_cdata: got %h, required 0", o_cdata); end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    clear_counts();
    w0 = l0_cnt + l1_cnt;
    repeat (5) @(posedge clk);
    #1;
    tests += 2;
    if (l0_cnt + l1_cnt != w0) begin fails++; $display("FAIL mid_no_writes: got %0d writes, required 0", l0_cnt + l1_cnt - w0); end
    if (o_busy !== 1'b0)       begin fails++; $display("FAIL mid_idle: got busy %b, required 0", o_busy); end
    for (int i = 0; i < 128; i++) begin d0_a[i] = DW'(i + 7); d1_a[i] = DW'(300 - i); end
    push_burst(0);
    start();
    send_burst(0, 1'b0, 1'b0, 1'b0);
    tests += 2;
    if (exp_q.size() != 0) begin fails++; $display("FAIL mid_restart_pending: got %0d left, required 0", exp_q.size()); end
    if (l0_cnt != 256)     begin fails++; $display("FAIL mid_restart_l0: got %0d, required 256", l0_cnt); end
  endtask

  initial begin
    clear_counts();
    fork
      monitor();
    join_none
    test_reset();
    test_single_burst();
    test_relu();
    test_pool();
    test_err();
    test_reset_mid();
    test_full_image();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/layer0_writeback.md
Name: layer0_writeback

Overview:
- Consumer end of the layer-0 convolution stream: accepts paired kernel results (kernel 0 / kernel 1) one row-pair burst at a time.
- Applies ReLU and writes every result to layer-0 result memory through a single shared write port.
- Computes 2x2 max-pool and writes it to layer-1 memory.
- Paces the producer with a one-cycle go-down pulse per completed burst. Sits between the convolution front end and the external result memory port.

Parameters:
- DW, 20, result word width (signed fixed point in, unsigned after ReLU).
- IMG_W, 64, pixels per row (power of two; 6 column bits).
- N_PAIRS, 32, row pairs per image.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- i_start  in  1  start pulse, sampled only in IDLE
- o_busy  out  1  high from accepted start until o_done
- i_valid  in  1  one result pair present this cycle
- i_data_0  in  DW  kernel-0 result, signed
- i_data_1  in  DW  kernel-1 result, signed
- o_go_down  out  1  one-cycle pulse: producer may start next row pair
- o_cwr  out  1  write strobe
- o_csel  out  3  target: 1 = L0 k0, 2 = L0 k1, 3 = L1 k0, 4 = L1 k1, 0 = idle
- o_caddr  out  12  write address
- o_cdata  out  DW  write data
- o_done  out  1  one-cycle pulse after the last burst completes
- o_err  out  1  sticky protocol error flag

Behaviour:
- Reset (async, active-high): state IDLE; all outputs 0; counters 0; buffer contents don't-care. Reset mid-operation aborts the image with no further writes.
- Burst order: 2*IMG_W valids per burst, row 2r columns 0..63, then row 2r+1 columns 0..63. Valids may have gaps.
- ReLU on capture: if bit DW-1 is set, store 0; else store the value. Buffer is 128 entries x 2 kernels, index cap_cnt = {rowbit, col}.
- States:
  - IDLE: o_busy=0. i_start moves to FILL with pair=0 and sets o_busy=1.
  - FILL: each i_valid stores an entry and increments cap_cnt. L0 drain runs concurrently. Moves to DRAIN when cap_cnt reaches 128.
  - DRAIN: continues L0 writes until all 256 are done, then moves to POOL.
  - POOL: 64 write cycles. For p = 0..31, the k0 write then the k1 write of max(e[2p], e[2p+1], e[64+2p], e[65+2p]), compared unsigned.
  - HANDOFF: one cycle. o_go_down=1, cap_cnt and write pointers cleared, pair increments. If the old pair was N_PAIRS-1, go to FINISH instead.
  - FINISH: one cycle. o_done=1, o_busy=0, then IDLE. o_go_down is not pulsed after the final pair.
- L0 drain: pointer wr_idx, with kernel toggle k0 then k1 per entry. A write issues in a cycle only if wr_idx < cap_cnt as registered at that cycle start, so the earliest write is the cycle after the first valid is captured. The drain issues at most one write per cycle.
- L0 address is {2*pair + idx[6], idx[5:0]}. L1 address is {2'b00, pair[4:0], p[4:0]}.
- Write outputs are registered: o_cwr, o_csel, o_caddr and o_cdata change together and each write is held for exactly one cycle. When there is no write, o_cwr=0 and o_csel=0.
- Per burst: 256 L0 writes followed by 64 L1 writes, no duplicates and no skips. After all 32 pairs: 8192 L0 writes and 2048 L1 writes in total.
- Errors set o_err (cleared only by reset). The offending sample is dropped and operation otherwise continues unchanged:
  - i_valid outside FILL.
  - i_valid when cap_cnt = 128.
- i_start outside IDLE: ignored.

Test Plan:
- Single burst, i_data_0 = idx and i_data_1 = idx+1000 streamed back-to-back → 256 L0 writes in k0/k1 alternation, addr 0..127, data matching. Then 64 L1 writes, e.g. p=0 k0 = 65, k1 = 1065. Then one o_go_down pulse.
- Negative inputs 20'hFFFFF and 20'h80000 → written data 0. 20'h7FFFF → written unchanged.
- Pool window values {5, 9, 3, 7} at entries 0, 1, 64, 65 → L1 addr 0 data 9. A window of all negatives → 0.
- Full image, 32 bursts each with random gaps in i_valid → counts of 8192 L0 and 2048 L1 writes, 31 o_go_down pulses, one o_done. Last L1 address is 0x3FF. o_busy then returns to 0.
- i_valid asserted during POOL and a 129th valid in one burst → o_err=1; write count and data unaffected.
- Reset asserted mid-FILL at cap_cnt = 40 → all outputs 0 immediately. A new i_start restarts at pair 0, addr 0.
